rptr_empty_sync: RTL

//  Read-side control for the async FIFO, parametrised successor of the basic read pointer/empty block.

---
 rtl/rptr_empty_sync.sv | 83 ++++++++
 1 files changed

// File: rtl/rptr_empty_sync.sv
// Read-side control for the async FIFO.
// Brings the write-domain Gray pointer into rclk through a short flop chain,
// keeps the binary/Gray read pointer and derives empty, almost-empty, fill
// level and an underflow pulse from the synchronised write pointer.
module rptr_empty_sync #(
   parameter int ADDW        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AEMPTY_TH   = 2
) (
   input  logic            rclk,
   input  logic            rrst_n,
   input  logic            rden,
   input  logic [ADDW:0]   wptr_gray,
   output logic [ADDW:0]   rptr_gray,
   output logic [ADDW-1:0] raddr,
   output logic            rempty,
   output logic            raempty,
   output logic [ADDW:0]   rlevel,
   output logic            runderflow
);

   localparam logic [ADDW:0] AE_TH = (ADDW+1)'(AEMPTY_TH);

   logic [ADDW:0] sync_q [SYNC_STAGES];
   logic [ADDW:0] wq;
   logic [ADDW:0] wbin;
   logic [ADDW:0] rbin;
   logic [ADDW:0] rbnext;
   logic [ADDW:0] rgnext;
   logic [ADDW:0] lvl_next;
   logic          rd_ok;

   // Synchronise the write Gray pointer into rclk; only the last stage is used.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         // NOTE: the synchroniser is a handful of ordinary flops, not a RAM,
         // so it is reset along with the rest of the state.
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample the previous
         // stage's old value, which is what makes this a shift chain.
         sync_q[0] <= wptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign wq = sync_q[SYNC_STAGES-1];

   // Next read pointer, Gray encoding and fill level seen from the read side.
   always_comb begin
      // NOTE: every output of this block gets a value before any condition,
      // so no path can leave a signal unassigned and infer a latch.
      rd_ok    = rden & ~rempty;
      rbnext   = rbin + {{ADDW{1'b0}}, rd_ok};
      rgnext   = (rbnext >> 1) ^ rbnext;
      wbin     = '0;
      for (int i = 0; i <= ADDW; i++) wbin[i] = ^(wq >> i);
      lvl_next = wbin - rbnext;
   end

   // Register pointers, flags and level; empty is a full-width Gray compare so
   // the wrap bit distinguishes empty from full.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin       <= '0;
         rptr_gray  <= '0;
         raddr      <= '0;
         rempty     <= 1'b1;
         raempty    <= 1'b1;
         rlevel     <= '0;
         runderflow <= 1'b0;
      end else begin
         rbin       <= rbnext;
         rptr_gray  <= rgnext;
         raddr      <= rbnext[ADDW-1:0];
         rempty     <= (rgnext == wq);
         raempty    <= (lvl_next <= AE_TH);
         rlevel     <= lvl_next;
         runderflow <= rden & rempty;
      end
   end

endmodule
